// File: rtl/io_controller.sv
// Console I/O sequencer: serves IN/OUT instructions for the multicycle control unit,
// stalling it until the user confirms an input with the enter button.
module io_controller #(
   parameter int SW_W    = 16,
   parameter int TIMEOUT = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_req,
   input  logic            out_req,
   input  logic [31:0]     out_data,
   input  logic [SW_W-1:0] switch,
   input  logic            enter,
   output logic [31:0]     in_data,
   output logic            in_ack,
   output logic            in_timeout,
   output logic            out_ack,
   output logic [31:0]     display_value,
   output logic            display_valid,
   output logic            stall,
   output logic [7:0]      in_count,
   output logic [2:0]      fsm_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      PRESS   = 3'd2,
      IN_ACK  = 3'd3,
      OUT_ACK = 3'd4
   } state_t;

   localparam bit          TO_EN = (TIMEOUT > 0);
   localparam logic [31:0] LIMIT = 32'(TIMEOUT);

   state_t      state, state_nxt;
   logic [31:0] wait_cnt;
   logic        timeout_flag;
   logic        timed_out;
   logic        cap_sw, cap_zero, cap_out, arm_entry;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cap_sw    = 1'b0;
      cap_zero  = 1'b0;
      cap_out   = 1'b0;
      arm_entry = 1'b0;
      timed_out = TO_EN && (wait_cnt >= LIMIT);
      case (state)
         IDLE: begin
            // out_req wins a tie; a held in_req is picked up on the return to IDLE
            if (out_req) begin
               state_nxt = OUT_ACK;
               cap_out   = 1'b1;
            end else if (in_req) begin
               state_nxt = ARM;
               arm_entry = 1'b1;
            end
         end
         ARM:     if (!enter) state_nxt = PRESS;
         PRESS: begin
            if (enter) begin
               state_nxt = IN_ACK;
               cap_sw    = 1'b1;
            end else if (timed_out) begin
               state_nxt = IN_ACK;
               cap_zero  = 1'b1;
            end
         end
         IN_ACK:  state_nxt = IDLE;
         OUT_ACK: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ack     = (state == IN_ACK);
      in_timeout = (state == IN_ACK) && timeout_flag;
      out_ack    = (state == OUT_ACK);
      stall      = (state == ARM) || (state == PRESS) ||
                   ((state == IDLE) && in_req && !out_req);
      fsm_state  = state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt      <= '0;
         timeout_flag  <= 1'b0;
         in_data       <= '0;
         in_count      <= '0;
         display_value <= '0;
         display_valid <= 1'b0;
      end else begin
         // Saturating, so a button held in ARM past the limit cannot wrap the count
         if (arm_entry)
            wait_cnt <= '0;
         else if (((state == ARM) || (state == PRESS)) && (wait_cnt != '1))
            wait_cnt <= wait_cnt + 32'd1;

         if (cap_sw) begin
            in_data      <= 32'(switch);
            timeout_flag <= 1'b0;
            in_count     <= in_count + 8'd1;
         end else if (cap_zero) begin
            in_data      <= '0;
            timeout_flag <= 1'b1;
            in_count     <= in_count + 8'd1;
         end

         if (cap_out) begin
            display_value <= out_data;
            display_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: directed front-panel scenarios plus randomized
// enter/switch waveforms predicted by a timing model of the console protocol.
module tb_io_controller;

   localparam int SW_W    = 16;
   localparam int TIMEOUT = 20;
   localparam int N       = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_req, out_req, enter;
   logic [31:0]     out_data;
   logic [SW_W-1:0] switch;
   logic [31:0]     in_data, display_value;
   logic            in_ack, in_timeout, out_ack, display_valid, stall;
   logic [7:0]      in_count;
   logic [2:0]      fsm_state;

   io_controller #(.SW_W(SW_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_req(in_req), .out_req(out_req),
      .out_data(out_data), .switch(switch), .enter(enter),
      .in_data(in_data), .in_ack(in_ack), .in_timeout(in_timeout),
      .out_ack(out_ack), .display_value(display_value),
      .display_valid(display_valid), .stall(stall), .in_count(in_count),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_in_data = '0;
   int          exp_count   = 0;
   logic [31:0] exp_disp    = '0;
   logic        exp_valid   = 1'b0;

   // enter / switch level presented before the j-th edge after in_req is raised
   logic            ent [N];
   logic [SW_W-1:0] swv [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Edge 0 enters ARM. First released level at edge p opens the press window.
   // The press window closes by timeout at edge max(TIMEOUT+1, p+1); a press on that edge wins.
   task automatic predict(output int ack, output logic [31:0] d, output logic to);
      int p, pe, limit;
      p = -1; pe = -1;
      for (int j = 1; j < N; j++) if (p < 0 && !ent[j]) p = j;
      if (p >= 0)
         for (int j = p + 1; j < N; j++) if (pe < 0 && ent[j]) pe = j;
      limit = (TIMEOUT + 1 > p + 1) ? TIMEOUT + 1 : p + 1;
      if (p < 0) begin
         ack = -1; d = '0; to = 1'b0;
      end else if (pe >= 0 && pe <= limit) begin
         ack = pe; d = 32'(swv[pe]); to = 1'b0;
      end else begin
         ack = limit; d = '0; to = 1'b1;
      end
   endtask

   task automatic fill_idle();
      for (int j = 0; j < N; j++) begin
         ent[j] = 1'b0;
         swv[j] = SW_W'($urandom);
      end
   endtask

   task automatic fill_rand();
      for (int j = 0; j < N; j++) begin
         ent[j] = (j < 40) ? ($urandom_range(0, 2) == 0) : 1'b0;
         swv[j] = SW_W'($urandom);
      end
   endtask

   task automatic run_input(input string tag);
      int          ack;
      logic [31:0] d;
      logic        to;
      predict(ack, d, to);
      if (ack < 0 || ack >= N) begin
         checks++; errors++;
         $display("FAIL %s_model observed=unbounded expected=ack_edge", tag);
      end else begin
         in_req = 1'b1; enter = ent[0]; switch = swv[0];
         #1;
         chk({tag, "_stall_req"}, 32'(stall), 32'd1);
         for (int j = 0; j <= ack; j++) begin
            cyc();
            if (j == ack) begin
               chk({tag, "_in_ack"}, 32'(in_ack), 32'd1);
               chk({tag, "_in_timeout"}, 32'(in_timeout), 32'(to));
               chk({tag, "_in_data"}, in_data, d);
               chk({tag, "_stall_ack"}, 32'(stall), 32'd0);
            end else begin
               chk({tag, "_no_ack"}, 32'(in_ack), 32'd0);
               chk({tag, "_stall_wait"}, 32'(stall), 32'd1);
               enter = ent[j+1]; switch = swv[j+1];
            end
         end
         in_req = 1'b0; enter = 1'b0;
         exp_in_data = d;
         exp_count   = (exp_count + 1) % 256;
         cyc();
         chk({tag, "_ack_pulse"}, 32'(in_ack), 32'd0);
         chk({tag, "_in_count"}, 32'(in_count), 32'(exp_count));
         chk({tag, "_in_data_held"}, in_data, exp_in_data);
      end
   endtask

   task automatic run_output(input string tag, input logic [31:0] val, input logic with_in);
      out_req = 1'b1; in_req = with_in; out_data = val;
      #1;
      chk({tag, "_stall_req"}, 32'(stall), 32'd0);
      cyc();
      exp_disp = val; exp_valid = 1'b1;
      chk({tag, "_out_ack"}, 32'(out_ack), 32'd1);
      chk({tag, "_display"}, display_value, exp_disp);
      chk({tag, "_valid"}, 32'(display_valid), 32'd1);
      chk({tag, "_stall_ack"}, 32'(stall), 32'd0);
      out_req = 1'b0; out_data = $urandom;
      cyc();
      chk({tag, "_ack_pulse"}, 32'(out_ack), 32'd0);
      chk({tag, "_display_held"}, display_value, exp_disp);
      chk({tag, "_in_data_unchanged"}, in_data, exp_in_data);
      chk({tag, "_stall_after"}, 32'(stall), 32'(with_in));
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_data"}, in_data, 32'd0);
      chk({tag, "_in_ack"}, 32'(in_ack), 32'd0);
      chk({tag, "_in_timeout"}, 32'(in_timeout), 32'd0);
      chk({tag, "_out_ack"}, 32'(out_ack), 32'd0);
      chk({tag, "_display"}, display_value, 32'd0);
      chk({tag, "_valid"}, 32'(display_valid), 32'd0);
      chk({tag, "_in_count"}, 32'(in_count), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
   endtask

   initial begin
      reset = 1'b1; in_req = 1'b0; out_req = 1'b0; enter = 1'b0;
      out_data = '0; switch = '0;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      chk_reset_values("reset");

      run_output("out_123", 32'h0000_007B, 1'b0);

      fill_idle();
      for (int j = 0; j < N; j++) swv[j] = 16'h00A5;
      ent[10] = 1'b1;
      run_input("press10");

      fill_idle();
      for (int j = 0; j < 5; j++) ent[j] = 1'b1;
      ent[8] = 1'b1; ent[9] = 1'b1; ent[12] = 1'b1;
      run_input("held");

      run_output("both", 32'hDEAD_BEEF, 1'b1);
      fill_idle();
      ent[4] = 1'b1;
      run_input("both_in");

      fill_idle();
      run_input("timeout");

      fill_idle();
      ent[TIMEOUT+1] = 1'b1;
      run_input("press_at_limit");

      fill_idle();
      ent[TIMEOUT+2] = 1'b1;
      run_input("press_after_limit");

      for (int k = 0; k < 20; k++) begin
         fill_rand();
         if ($urandom_range(0, 1) == 1) run_output("rnd_out", $urandom, 1'b0);
         run_input("rnd_in");
      end

      in_req = 1'b1; enter = 1'b0; switch = 16'h1234;
      repeat (3) cyc();
      chk("mid_stall", 32'(stall), 32'd1);
      reset = 1'b1; in_req = 1'b0;
      cyc();
      chk_reset_values("mid_reset");
      reset = 1'b0;
      exp_in_data = '0; exp_count = 0; exp_disp = '0; exp_valid = 1'b0;
      cyc();
      chk("mid_no_ack", 32'(in_ack), 32'd0);
      chk("mid_idle_stall", 32'(stall), 32'd0);

      for (int k = 0; k < 256; k++) begin
         fill_rand();
         run_input("wrap");
      end
      chk("wrap_count", 32'(in_count), 32'd0);
      chk("wrap_valid", 32'(display_valid), 32'(exp_valid));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
